// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register-file geometry and the writeback entry
// carried through the mul/div result FIFO.
package cpu_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned NUM_REGS = 32;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of writeback entries. Status flags are registered; the
// head entry is a plain read mux on the storage, hence the _c suffix.
module wb_fifo
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  wb_entry_t                     wr_entry,
  input  logic                          pop,
  output wb_entry_t                     head_c,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(DEPTH+1)-1:0]    count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  wb_entry_t          mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count_nxt;
  logic               do_push;
  logic               do_pop;

  // Overflow/underflow requests are ignored rather than corrupting state.
  always_comb begin
    do_push   = push && !full;
    do_pop    = pop && !empty;
    count_nxt = count;
    if (do_push && !do_pop) begin
      count_nxt = count + CNT_W'(1);
    end else if (do_pop && !do_push) begin
      count_nxt = count - CNT_W'(1);
    end
    head_c = mem[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_nxt;
      full  <= (count_nxt == CNT_W'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

  // Storage needs no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_entry;
  end

endmodule

// File: rtl/reg_wb_arbiter.sv
// Register-file write-port master: fixed-priority ALU writeback merged with a
// FIFO-buffered mul/div writeback, plus pending-destination scoreboard.
module reg_wb_arbiter
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                alu_valid,
  input  logic [ADDR_W-1:0]   alu_rd,
  input  logic [DATA_W-1:0]   alu_data,
  input  logic                md_valid,
  output logic                md_ready,
  input  logic [ADDR_W-1:0]   md_rd,
  input  logic [DATA_W-1:0]   md_data,
  input  logic                md_issue,
  input  logic [ADDR_W-1:0]   md_issue_rd,
  output logic [NUM_REGS-1:0] busy_vec,
  output logic                stall_req,
  output logic                REG_write_1,
  output logic [ADDR_W-1:0]   REG_address_wr,
  output logic [DATA_W-1:0]   REG_data_wb_in1
);

  localparam int unsigned CNT_W    = $clog2(DEPTH + 1);
  localparam int unsigned STARVE_W = $clog2(STARVE_MAX + 1);

  wb_entry_t             md_entry;
  wb_entry_t             head;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [CNT_W-1:0]      fifo_count;

  logic                  alu_sel;
  logic                  drain;
  logic                  md_wr;
  logic                  push;
  logic                  wr_nxt;
  logic [ADDR_W-1:0]     addr_nxt;
  logic [DATA_W-1:0]     data_nxt;
  logic [NUM_REGS-1:0]   busy_nxt;
  logic [STARVE_W-1:0]   starve_cnt;
  logic [STARVE_W-1:0]   starve_nxt;
  logic                  stall_nxt;

  assign md_entry = '{rd: md_rd, data: md_data};
  assign md_ready = (fifo_count < CNT_W'(DEPTH));

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .wr_entry (md_entry),
    .pop      (drain),
    .head_c   (head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  // Selection, scoreboard and starvation next-state.
  always_comb begin
    alu_sel    = alu_valid && (alu_rd != '0);
    drain      = !alu_sel && !fifo_empty;
    md_wr      = drain && (head.rd != '0);
    push       = md_valid && md_ready;

    wr_nxt     = alu_sel || md_wr;
    addr_nxt   = REG_address_wr;
    data_nxt   = REG_data_wb_in1;
    busy_nxt   = busy_vec;
    starve_nxt = starve_cnt;

    if (alu_sel) begin
      addr_nxt = alu_rd;
      data_nxt = alu_data;
    end else if (md_wr) begin
      addr_nxt = head.rd;
      data_nxt = head.data;
    end

    // Clear first so a same-cycle issue to the retiring index wins.
    if (md_wr) busy_nxt[head.rd] = 1'b0;
    if (md_issue && (md_issue_rd != '0)) busy_nxt[md_issue_rd] = 1'b1;
    busy_nxt[0] = 1'b0;

    if (fifo_empty || drain) begin
      starve_nxt = '0;
    end else if (starve_cnt < STARVE_W'(STARVE_MAX)) begin
      starve_nxt = starve_cnt + STARVE_W'(1);
    end
    stall_nxt = (starve_nxt >= STARVE_W'(STARVE_MAX));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      REG_write_1     <= 1'b0;
      REG_address_wr  <= '0;
      REG_data_wb_in1 <= '0;
      busy_vec        <= '0;
      starve_cnt      <= '0;
      stall_req       <= 1'b0;
    end else begin
      REG_write_1     <= wr_nxt;
      REG_address_wr  <= addr_nxt;
      REG_data_wb_in1 <= data_nxt;
      busy_vec        <= busy_nxt;
      starve_cnt      <= starve_nxt;
      stall_req       <= stall_nxt;
    end
  end

  // Issue-stage obligations; a re-issue is legal only as the old result retires.
  a_alu_not_pending : assert property (@(posedge clk) disable iff (rst)
    alu_sel |-> !busy_vec[alu_rd]);
  a_issue_not_pending : assert property (@(posedge clk) disable iff (rst)
    (md_issue && (md_issue_rd != '0)) |->
      (!busy_vec[md_issue_rd] || (md_wr && (head.rd == md_issue_rd))));
  a_ready_vs_full : assert property (@(posedge clk) disable iff (rst)
    md_ready == !fifo_full);

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Bench for reg_wb_arbiter: ALU vector table, scoreboard of expected register
// writes popped on each strobe, and hand sequences for mul/div corner cases.
module tb_reg_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        md_valid;
  logic        md_ready;
  logic [4:0]  md_rd;
  logic [31:0] md_data;
  logic        md_issue;
  logic [4:0]  md_issue_rd;
  logic [31:0] busy_vec;
  logic        stall_req;
  logic        REG_write_1;
  logic [4:0]  REG_address_wr;
  logic [31:0] REG_data_wb_in1;

  reg_wb_arbiter #(.DEPTH(4), .STARVE_MAX(8)) dut (
    .clk             (clk),
    .rst             (rst),
    .alu_valid       (alu_valid),
    .alu_rd          (alu_rd),
    .alu_data        (alu_data),
    .md_valid        (md_valid),
    .md_ready        (md_ready),
    .md_rd           (md_rd),
    .md_data         (md_data),
    .md_issue        (md_issue),
    .md_issue_rd     (md_issue_rd),
    .busy_vec        (busy_vec),
    .stall_req       (stall_req),
    .REG_write_1     (REG_write_1),
    .REG_address_wr  (REG_address_wr),
    .REG_data_wb_in1 (REG_data_wb_in1)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic        v;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        exp_wr;
    logic [4:0]  exp_addr;
    logic [31:0] exp_data;
  } alu_vec_t;

  wr_t      exp_q[$];
  wr_t      sb_e;
  alu_vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic wr_t mk(input int rd, input logic [31:0] d);
    wr_t w;
    w.rd   = 5'(rd);
    w.data = d;
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (!rst && REG_write_1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected_strobe actual addr=%0d data=%0h required no write",
                 REG_address_wr, REG_data_wb_in1);
      end else begin
        sb_e = exp_q.pop_front();
        chk("sb_addr", 64'(REG_address_wr), 64'(sb_e.rd));
        chk("sb_data", 64'(REG_data_wb_in1), 64'(sb_e.data));
      end
    end
  end

  initial begin
    vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b1, 5'd5,  32'hDEADBEEF};
    vecs[1] = '{1'b0, 5'd5,  32'h00000000, 1'b0, 5'd5,  32'hDEADBEEF};
    vecs[2] = '{1'b1, 5'd0,  32'h11111111, 1'b0, 5'd5,  32'hDEADBEEF};
    vecs[3] = '{1'b1, 5'd31, 32'hA5A5A5A5, 1'b1, 5'd31, 32'hA5A5A5A5};
    vecs[4] = '{1'b1, 5'd1,  32'h00000001, 1'b1, 5'd1,  32'h00000001};
    vecs[5] = '{1'b0, 5'd2,  32'hFFFFFFFF, 1'b0, 5'd1,  32'h00000001};

    rst = 1'b1; alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    md_valid = 1'b1; md_rd = 5'd6; md_data = 32'h66666666;
    md_issue = 1'b0; md_issue_rd = '0;

    // Reset held two cycles with a mul/div result offered.
    tick(); tick();
    chk("rst_write", 64'(REG_write_1), 64'd0);
    chk("rst_addr", 64'(REG_address_wr), 64'd0);
    chk("rst_data", 64'(REG_data_wb_in1), 64'd0);
    chk("rst_stall", 64'(stall_req), 64'd0);
    chk("rst_busy", 64'(busy_vec), 64'd0);
    rst = 1'b0; md_valid = 1'b0;
    chk("rst_ready", 64'(md_ready), 64'd1);
    tick(); tick();
    chk("rst_no_drain", 64'(REG_write_1), 64'd0);

    // ALU table.
    for (int i = 0; i < 6; i++) begin
      alu_valid = vecs[i].v; alu_rd = vecs[i].rd; alu_data = vecs[i].data;
      if (vecs[i].exp_wr) exp_q.push_back(mk(int'(vecs[i].rd), vecs[i].data));
      tick();
      chk("alu_write", 64'(REG_write_1), 64'(vecs[i].exp_wr));
      chk("alu_addr", 64'(REG_address_wr), 64'(vecs[i].exp_addr));
      chk("alu_data", 64'(REG_data_wb_in1), 64'(vecs[i].exp_data));
    end
    alu_valid = 1'b0;

    // Mul/div with scoreboard tracking.
    md_issue = 1'b1; md_issue_rd = 5'd7;
    tick();
    md_issue = 1'b0;
    chk("md_busy_set", 64'(busy_vec), 64'h80);
    tick();
    chk("md_busy_hold", 64'(busy_vec), 64'h80);
    md_valid = 1'b1; md_rd = 5'd7; md_data = 32'h12345678;
    exp_q.push_back(mk(7, 32'h12345678));
    tick();
    md_valid = 1'b0;
    chk("md_lat1_nowrite", 64'(REG_write_1), 64'd0);
    chk("md_lat1_busy", 64'(busy_vec), 64'h80);
    tick();
    chk("md_lat2_write", 64'(REG_write_1), 64'd1);
    chk("md_busy_clear", 64'(busy_vec), 64'd0);

    // Back-pressure and starvation under continuous ALU traffic.
    alu_valid = 1'b1; alu_rd = 5'd3;
    for (int c = 0; c < 12; c++) begin
      alu_data = 32'hC0000000 | 32'(c);
      exp_q.push_back(mk(3, alu_data));
      if (c < 5) begin
        md_valid = 1'b1; md_rd = 5'(10 + c); md_data = 32'hA0000000 + 32'(c);
      end else begin
        md_valid = 1'b0;
      end
      chk("bp_ready", 64'(md_ready), 64'(c < 4));
      tick();
      chk("bp_stall", 64'(stall_req), 64'(c >= 8));
    end
    alu_valid = 1'b0; md_valid = 1'b0;
    exp_q.push_back(mk(10, 32'hA0000000));
    chk("bp_full_ready", 64'(md_ready), 64'd0);
    tick();
    chk("bp_ready_after_pop", 64'(md_ready), 64'd1);
    chk("bp_stall_clear", 64'(stall_req), 64'd0);
    chk("bp_drain_write", 64'(REG_write_1), 64'd1);
    for (int i = 1; i < 4; i++) begin
      exp_q.push_back(mk(10 + i, 32'hA0000000 + 32'(i)));
      tick();
      chk("bp_drain_rest", 64'(REG_write_1), 64'd1);
    end
    tick();
    chk("bp_rejected_fifth", 64'(REG_write_1), 64'd0);

    // rd==0: dropped ALU write lets the FIFO drain; rd 0 entry pops silently.
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h33;
    md_valid = 1'b1; md_rd = 5'd9; md_data = 32'h99;
    exp_q.push_back(mk(3, 32'h33));
    tick();
    alu_rd = 5'd0; alu_data = 32'hBAD;
    md_rd = 5'd0; md_data = 32'h55;
    exp_q.push_back(mk(9, 32'h99));
    tick();
    chk("rd0_alu_drop_drain", 64'(REG_write_1), 64'd1);
    chk("rd0_drain_addr", 64'(REG_address_wr), 64'd9);
    alu_valid = 1'b0; md_valid = 1'b0;
    tick();
    chk("rd0_entry_no_strobe", 64'(REG_write_1), 64'd0);
    chk("rd0_addr_hold", 64'(REG_address_wr), 64'd9);
    tick();
    chk("rd0_fifo_empty", 64'(REG_write_1), 64'd0);

    // Set and clear of the same index in one cycle: set wins.
    md_issue = 1'b1; md_issue_rd = 5'd4;
    tick();
    md_issue = 1'b0;
    chk("race_busy_set", 64'(busy_vec), 64'h10);
    md_valid = 1'b1; md_rd = 5'd4; md_data = 32'h44;
    tick();
    md_valid = 1'b0;
    md_issue = 1'b1; md_issue_rd = 5'd4;
    exp_q.push_back(mk(4, 32'h44));
    tick();
    md_issue = 1'b0;
    chk("race_write", 64'(REG_write_1), 64'd1);
    chk("race_busy_kept", 64'(busy_vec), 64'h10);
    md_issue = 1'b1; md_issue_rd = 5'd0;
    tick();
    md_issue = 1'b0;
    chk("busy_bit0_zero", 64'(busy_vec), 64'h10);

    tick(); tick();
    chk("sb_all_writes_seen", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
